// File: rtl/ones_comp_checksum_checker.sv
// Receive-side ones' complement checksum checker with saturating frame/error counters.
// Latency: result valid on the edge accepting the last word; held in DONE until out_ready.
// Backpressure: in_ready drops while a result is held; offered words stall, never drop.
module ones_comp_checksum_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               ok_q, ok_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH:0]     raw_sum;
    logic [WIDTH-1:0]   acc_next;
    logic               accept;
    logic               next_ok;

    // End-around carry: one fold suffices since the raw sum is at most 2*(2^W-1).
    assign raw_sum  = {1'b0, acc_q} + {1'b0, in_data};
    assign acc_next = raw_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw_sum[WIDTH]};
    assign next_ok  = &acc_next;

    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        ok_d        = ok_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        sum_d   = acc_next;
                        ok_d    = next_ok;
                        acc_d   = '0;
                        state_d = S_DONE;
                        if (frame_cnt_q != {CNT_W{1'b1}}) begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                        if (!next_ok && (err_cnt_q != {CNT_W{1'b1}})) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        acc_d   = acc_next;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            ok_q        <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            ok_q        <= ok_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_ok    = ok_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ones_comp_checksum_checker.sv
// Directed bench for ones_comp_checksum_checker: frames with hand-computed sums.
module tb_ones_comp_checksum_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_ok;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;
    int exp_errs    = 0;

    ones_comp_checksum_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ok    (out_ok),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers one word and returns #1 after the edge that accepted it.
    task automatic send(input logic [3:0] d, input logic l);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (guard >= 50) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (l) begin
            exp_frames = (exp_frames < 255) ? exp_frames + 1 : 255;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 4'h0 || out_ok !== 1'b0 ||
            frame_cnt !== 8'h00 || err_cnt !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: vld=%b sum=%h ok=%b fc=%h ec=%h rdy=%b, required 0 0 0 00 00 1",
                     out_valid, out_sum, out_ok, frame_cnt, err_cnt, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 4'hF || out_ok !== 1'b1 ||
            frame_cnt !== 8'd1 || err_cnt !== 8'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL good_frame: vld=%b sum=%h ok=%b fc=%0d ec=%0d rdy=%b, required 1 f 1 1 0 0",
                     out_valid, out_sum, out_ok, frame_cnt, err_cnt, in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL good_frame_one_cycle: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bad_frame();
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hC, 1'b1);
        exp_errs++;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 4'h1 || out_ok !== 1'b0 ||
            frame_cnt !== 8'd2 || err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL bad_frame: vld=%b sum=%h ok=%b fc=%0d ec=%0d, required 1 1 0 2 1",
                     out_valid, out_sum, out_ok, frame_cnt, err_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_edge_words();
        logic [3:0] first [3];
        logic       multi [3];
        logic [3:0] exp_sum [3];
        logic       exp_ok [3];
        first = '{4'hF, 4'h0, 4'hF};
        multi = '{1'b0, 1'b0, 1'b1};
        exp_sum = '{4'hF, 4'h0, 4'hF};
        exp_ok = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (multi[i]) begin
                send(first[i], 1'b0);
                send(4'hF, 1'b1);
            end else begin
                send(first[i], 1'b1);
            end
            if (!exp_ok[i]) exp_errs++;
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum[i] || out_ok !== exp_ok[i] ||
                frame_cnt !== exp_frames[7:0] || err_cnt !== exp_errs[7:0]) begin
                miscompares++;
                $display("FAIL edge_word_%0d: vld=%b sum=%h ok=%b fc=%0d ec=%0d, required 1 %h %b %0d %0d",
                         i, out_valid, out_sum, out_ok, frame_cnt, err_cnt,
                         exp_sum[i], exp_ok[i], exp_frames, exp_errs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'hF || out_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_cycle_%0d: vld=%b rdy=%b sum=%h ok=%b, required 1 0 f 1",
                         c, out_valid, in_ready, out_sum, out_ok);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        send(4'h5, 1'b0);
        send(4'hA, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 4'hF || out_ok !== 1'b1 || frame_cnt !== exp_frames[7:0]) begin
            miscompares++;
            $display("FAIL second_frame: vld=%b sum=%h ok=%b fc=%0d, required 1 f 1 %0d",
                     out_valid, out_sum, out_ok, frame_cnt, exp_frames);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        send(4'h7, 1'b0);
        send(4'h3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        exp_errs   = 0;
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 4'h0 || out_ok !== 1'b0 ||
            frame_cnt !== 8'h00 || err_cnt !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: vld=%b sum=%h ok=%b fc=%h ec=%h rdy=%b, required 0 0 0 00 00 1",
                     out_valid, out_sum, out_ok, frame_cnt, err_cnt, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'h5, 1'b0);
        send(4'hA, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 4'hF || out_ok !== 1'b1 ||
            frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL post_reset_frame: vld=%b sum=%h ok=%b fc=%0d ec=%0d, required 1 f 1 1 0",
                     out_valid, out_sum, out_ok, frame_cnt, err_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            send(4'h1, 1'b1);
            exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
            @(posedge clk); #1;
            if (n == 99) begin
                vectors++;
                if (frame_cnt !== exp_frames[7:0] || err_cnt !== exp_errs[7:0]) begin
                    miscompares++;
                    $display("FAIL count_mid: fc=%0d ec=%0d, required %0d %0d",
                             frame_cnt, err_cnt, exp_frames, exp_errs);
                end
            end
        end
        vectors++;
        if (frame_cnt !== 8'hFF || err_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL saturation: fc=%h ec=%h, required ff ff", frame_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_edge_words();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
